// File: rtl/ct_ciu_snb_age_pkg.sv
// ct_ciu_snb_age_pkg: shared sizes and entry state encodings for the SNB age controller
package ct_ciu_snb_age_pkg;
  localparam int SNB_DEPTH = 24;
  localparam int SNB_CNT_W = $clog2(SNB_DEPTH + 1);
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ISSUED = 2'b10
  } snb_state_e;
endpackage

// File: rtl/ct_ciu_snb_age_entry.sv
// ct_ciu_snb_age_entry: one SNB entry's request FSM and age row
// Inputs: alloc_hit (grant lands here), alloc_mask (older entries at grant time),
//   dealloc_col (entries leaving, cleared from this row), sel_bit/issue_rdy (issue),
//   dealloc_bit (this entry completes), reissue_bit under CIU_SNB_AGE_REISSUE_EN.
// Outputs: req_vld (WAIT), entry_vld (occupied), age_row (bit j = entry j older).
module ct_ciu_snb_age_entry
  import ct_ciu_snb_age_pkg::*;
#(
  parameter int DEPTH = SNB_DEPTH,
  parameter int IDX   = 0
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             alloc_hit,
  input  logic [DEPTH-1:0] alloc_mask,
  input  logic [DEPTH-1:0] dealloc_col,
  input  logic             sel_bit,
  input  logic             issue_rdy,
  input  logic             dealloc_bit,
`ifdef CIU_SNB_AGE_REISSUE_EN
  input  logic             reissue_bit,
`endif
  output logic             req_vld,
  output logic             entry_vld,
  output logic [DEPTH-1:0] age_row
);
  localparam logic [DEPTH-1:0] SELF = DEPTH'(1) << IDX;
  snb_state_e       state_q, state_d;
  logic [DEPTH-1:0] age_q, age_d;
  logic             dealloc_hit, issue_hit, reissue_hit;
  always_comb begin
    dealloc_hit = dealloc_bit & (state_q != IDLE);
    issue_hit   = (state_q == WAIT) & sel_bit & issue_rdy;
`ifdef CIU_SNB_AGE_REISSUE_EN
    reissue_hit = (state_q == ISSUED) & reissue_bit;
`else
    reissue_hit = 1'b0;
`endif
    state_d = dealloc_hit ? IDLE : alloc_hit ? WAIT : issue_hit ? ISSUED : reissue_hit ? WAIT : state_q;
    age_d   = dealloc_hit ? '0 : alloc_hit ? (alloc_mask & ~SELF) : (age_q & ~dealloc_col);
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
    end
  end
  assign req_vld   = state_q == WAIT;
  assign entry_vld = state_q != IDLE;
  assign age_row   = age_q;
endmodule

// File: rtl/ct_ciu_snb_age_ctrl.sv
// ct_ciu_snb_age_ctrl: SNB entry allocation, age matrix and request-state control
// Inputs: alloc_req, sel (one-hot winner), issue_rdy, dealloc_vld (multi-hot),
//   reissue_vld when CIU_SNB_AGE_REISSUE_EN is defined.
// Outputs: alloc_gnt/alloc_idx, req_vld, entry_age_vect (entry i at [i*DEPTH +: DEPTH]),
//   entry_vld, full, empty, vld_cnt.
module ct_ciu_snb_age_ctrl
  import ct_ciu_snb_age_pkg::*;
#(
  parameter int DEPTH = SNB_DEPTH,
  parameter int CNT_W = SNB_CNT_W
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic                   alloc_req,
  output logic                   alloc_gnt,
  output logic [DEPTH-1:0]       alloc_idx,
  input  logic [DEPTH-1:0]       sel,
  input  logic                   issue_rdy,
  input  logic [DEPTH-1:0]       dealloc_vld,
`ifdef CIU_SNB_AGE_REISSUE_EN
  input  logic [DEPTH-1:0]       reissue_vld,
`endif
  output logic [DEPTH-1:0]       req_vld,
  output logic [DEPTH*DEPTH-1:0] entry_age_vect,
  output logic [DEPTH-1:0]       entry_vld,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       vld_cnt
);
  logic [DEPTH-1:0] free, alloc_oh, alloc_hit, alloc_mask;
  logic [CNT_W-1:0] vld_cnt_q, vld_cnt_d;
  always_comb begin
    free       = ~entry_vld;
    alloc_oh   = free & (~free + DEPTH'(1));
    alloc_gnt  = alloc_req & ~full;
    alloc_hit  = alloc_gnt ? alloc_oh : '0;
    alloc_mask = entry_vld & ~dealloc_vld;
    vld_cnt_d  = vld_cnt_q + CNT_W'(alloc_gnt) - CNT_W'($countones(dealloc_vld & entry_vld));
  end
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) vld_cnt_q <= '0;
    else vld_cnt_q <= vld_cnt_d;
  end
  assign alloc_idx = alloc_oh;
  assign full      = vld_cnt_q == CNT_W'(DEPTH);
  assign empty     = vld_cnt_q == '0;
  assign vld_cnt   = vld_cnt_q;
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    ct_ciu_snb_age_entry #(.DEPTH(DEPTH), .IDX(i)) u_entry (
      .forever_cpuclk(forever_cpuclk),
      .cpurst_b      (cpurst_b),
      .alloc_hit     (alloc_hit[i]),
      .alloc_mask    (alloc_mask),
      .dealloc_col   (dealloc_vld),
      .sel_bit       (sel[i]),
      .issue_rdy     (issue_rdy),
      .dealloc_bit   (dealloc_vld[i]),
`ifdef CIU_SNB_AGE_REISSUE_EN
      .reissue_bit   (reissue_vld[i]),
`endif
      .req_vld       (req_vld[i]),
      .entry_vld     (entry_vld[i]),
      .age_row       (entry_age_vect[i*DEPTH +: DEPTH])
    );
  end
endmodule

// File: tb/tb_ct_ciu_snb_age_ctrl.sv
// tb_ct_ciu_snb_age_ctrl: directed self-checking bench for the SNB age controller
module tb_ct_ciu_snb_age_ctrl;
  localparam int D = 24;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           alloc_req = 1'b0;
  logic           alloc_gnt;
  logic [D-1:0]   alloc_idx;
  logic [D-1:0]   sel = '0;
  logic           issue_rdy = 1'b0;
  logic [D-1:0]   dealloc_vld = '0;
`ifdef CIU_SNB_AGE_REISSUE_EN
  logic [D-1:0]   reissue_vld = '0;
`endif
  logic [D-1:0]   req_vld;
  logic [D*D-1:0] entry_age_vect;
  logic [D-1:0]   entry_vld;
  logic           full;
  logic           empty;
  logic [4:0]     vld_cnt;
  int n_chk = 0;
  int n_fail = 0;

  ct_ciu_snb_age_ctrl dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_n),
    .alloc_req     (alloc_req),
    .alloc_gnt     (alloc_gnt),
    .alloc_idx     (alloc_idx),
    .sel           (sel),
    .issue_rdy     (issue_rdy),
    .dealloc_vld   (dealloc_vld),
`ifdef CIU_SNB_AGE_REISSUE_EN
    .reissue_vld   (reissue_vld),
`endif
    .req_vld       (req_vld),
    .entry_age_vect(entry_age_vect),
    .entry_vld     (entry_vld),
    .full          (full),
    .empty         (empty),
    .vld_cnt       (vld_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [D-1:0] age(input int i);
    return entry_age_vect[i*D +: D];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_cnt", 64'(vld_cnt), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_req", 64'(req_vld), 64'd0);
    chk("rst_vld", 64'(entry_vld), 64'd0);
    chk("rst_age", 64'(|entry_age_vect), 64'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    #1;
    alloc_req = 1'b1;
    #1;
    chk("gnt_after_rst", 64'(alloc_gnt), 64'd1);
    chk("idx0", 64'(alloc_idx), 64'h000001);
    cyc();
    chk("idx1", 64'(alloc_idx), 64'h000002);
    cyc();
    chk("idx2", 64'(alloc_idx), 64'h000004);
    cyc();
    alloc_req = 1'b0;
    #1;
    chk("age0_a", 64'(age(0)), 64'h0);
    chk("age1_a", 64'(age(1)), 64'h000001);
    chk("age2_a", 64'(age(2)), 64'h000003);
    chk("req_3", 64'(req_vld), 64'h000007);
    chk("cnt_3", 64'(vld_cnt), 64'd3);
    dealloc_vld = 24'h000001;
    cyc();
    dealloc_vld = '0;
    #1;
    chk("age1_b", 64'(age(1)), 64'h0);
    chk("age2_b", 64'(age(2)), 64'h000002);
    chk("vld_b", 64'(entry_vld), 64'h000006);
    chk("cnt_b", 64'(vld_cnt), 64'd2);
    alloc_req = 1'b1;
    #1;
    chk("realloc_idx", 64'(alloc_idx), 64'h000001);
    cyc();
    alloc_req = 1'b0;
    #1;
    chk("age0_b", 64'(age(0)), 64'h000006);
    chk("cnt_c", 64'(vld_cnt), 64'd3);
    sel = 24'h000002;
    cyc();
    cyc();
    chk("hold_no_rdy", 64'(req_vld), 64'h000007);
    issue_rdy = 1'b1;
    #1;
    chk("req_pre_issue", 64'(req_vld), 64'h000007);
    cyc();
    sel = '0;
    issue_rdy = 1'b0;
    #1;
    chk("req_issued", 64'(req_vld), 64'h000005);
    chk("vld_issued", 64'(entry_vld), 64'h000007);
    dealloc_vld = 24'h000002;
    cyc();
    dealloc_vld = '0;
    #1;
    chk("vld_dealloc1", 64'(entry_vld), 64'h000005);
    chk("cnt_dealloc1", 64'(vld_cnt), 64'd2);
    chk("age0_c", 64'(age(0)), 64'h000004);
    chk("age2_c", 64'(age(2)), 64'h0);
    sel = 24'h000004;
    issue_rdy = 1'b1;
    dealloc_vld = 24'h000004;
    cyc();
    sel = '0;
    issue_rdy = 1'b0;
    dealloc_vld = '0;
    #1;
    chk("vld_dealloc_prio", 64'(entry_vld), 64'h000001);
    chk("req_dealloc_prio", 64'(req_vld), 64'h000001);
    chk("cnt_dealloc_prio", 64'(vld_cnt), 64'd1);
    chk("age0_d", 64'(age(0)), 64'h0);
    alloc_req = 1'b1;
    repeat (23) cyc();
    chk("full", 64'(full), 64'd1);
    chk("cnt_full", 64'(vld_cnt), 64'd24);
    chk("gnt_full", 64'(alloc_gnt), 64'd0);
    chk("age23_full", 64'(age(23)), 64'h7FFFFF);
    chk("age1_full", 64'(age(1)), 64'h000001);
    dealloc_vld = 24'h800000;
    #1;
    chk("gnt_full_dealloc", 64'(alloc_gnt), 64'd0);
    cyc();
    dealloc_vld = '0;
    #1;
    chk("cnt_23", 64'(vld_cnt), 64'd23);
    chk("full_off", 64'(full), 64'd0);
    chk("gnt_23", 64'(alloc_gnt), 64'd1);
    chk("idx_23", 64'(alloc_idx), 64'h800000);
    cyc();
    alloc_req = 1'b0;
    #1;
    chk("cnt_refull", 64'(vld_cnt), 64'd24);
    chk("age23_b", 64'(age(23)), 64'h7FFFFF);
`ifdef CIU_SNB_AGE_REISSUE_EN
    sel = 24'h000020;
    issue_rdy = 1'b1;
    cyc();
    sel = '0;
    issue_rdy = 1'b0;
    #1;
    chk("req_issue5", 64'(req_vld), 64'hFFFFDF);
    reissue_vld = 24'h000020;
    cyc();
    reissue_vld = '0;
    #1;
    chk("req_reissue5", 64'(req_vld), 64'hFFFFFF);
    chk("age5_reissue", 64'(age(5)), 64'h00001F);
`endif
    dealloc_vld = 24'hFFFC00;
    cyc();
    dealloc_vld = '0;
    #1;
    chk("cnt_10", 64'(vld_cnt), 64'd10);
    chk("vld_10", 64'(entry_vld), 64'h0003FF);
    chk("age9_10", 64'(age(9)), 64'h0001FF);
    #1;
    rst_n = 1'b0;
    alloc_req = 1'b1;
    #1;
    chk("arst_cnt", 64'(vld_cnt), 64'd0);
    chk("arst_vld", 64'(entry_vld), 64'd0);
    chk("arst_req", 64'(req_vld), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_age", 64'(|entry_age_vect), 64'd0);
    chk("arst_gnt", 64'(alloc_gnt), 64'd1);
    alloc_req = 1'b0;
    cyc();
    rst_n = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
